wave_capture_ctrl: RTL and testbench
====================================

WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 Parameter SAMPLE_W, default 16, width of the signed input sample.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 new_sample  input  1  single-cycle strobe; sample_in is valid this cycle.
REQ-005 sample_in  input  SAMPLE_W  signed two's-complement audio sample.
REQ-006 frame_done  input  1  single-cycle strobe from the display side at the end of each frame.
REQ-007 write_enable  output  1  sample RAM write strobe.
REQ-008 write_address  output  9  RAM address {capture half, 8-bit index}.
REQ-009 write_sample  output  8  offset-binary sample written to the RAM.
REQ-010 read_index  output  1  RAM half that the wave display reads; this block owns it.
REQ-011 state  output  2  current FSM state, for debug.

Function
REQ-012 The FSM SHALL have the states ARMED=0, ACTIVE=1 and WAIT=2; encoding 3 SHALL be unreachable, and if ever entered SHALL return to ARMED on the next clock.
REQ-013 ARMED: on new_sample with prev_sample<0 and sample_in>=0 (rising zero crossing), the block SHALL write that sample at index 0 and go to ACTIVE.
REQ-014 prev_sample SHALL update on every new_sample strobe in every state; new_sample low SHALL leave prev_sample and all counters unchanged.
REQ-015 ACTIVE: each new_sample SHALL write one sample at the next index; the write of index 255 SHALL move the FSM to WAIT on the same edge.
REQ-016 Exactly 256 writes SHALL occur per capture, at indices 0..255 in order, with no gaps or repeats.
REQ-017 write_address SHALL be {~read_index, index}, so writes never target the half being displayed.
REQ-018 write_sample SHALL be sample_in[SAMPLE_W-1:SAMPLE_W-8] with its MSB inverted (i.e. +128 offset), so -32768 maps to 0x00, 0 to 0x80 and 32767 to 0xFF.
REQ-019 write_enable, write_address and write_sample SHALL be registered: exactly 1 cycle of latency from the new_sample cycle, with write_enable high for exactly one cycle per write.
REQ-020 WAIT: the block SHALL ignore new_sample for writes; on frame_done it SHALL toggle read_index and go to ARMED on the same edge.
REQ-021 frame_done in ARMED or ACTIVE SHALL be ignored; read_index SHALL never toggle mid-capture.
REQ-022 When frame_done and new_sample coincide in WAIT, the new_sample SHALL NOT be written and SHALL NOT be treated as a trigger, but SHALL still update prev_sample.
REQ-023 The 8-bit index SHALL NOT wrap within a capture; it SHALL reset to 0 on every ARMED entry.

Reset
REQ-024 Asserting reset (low) SHALL immediately force state=ARMED, read_index=0, index=0, prev_sample=0, write_enable=0, write_address=0 and write_sample=0.
REQ-025 Reset asserted during ACTIVE SHALL abandon the partial capture; the display half SHALL remain read_index=0.
REQ-026 Reset deassertion is synchronised externally; the first new_sample after reset SHALL see prev_sample=0, so a first sample >=0 SHALL NOT trigger.

Configuration
REQ-027 Macro WAVE_CAPTURE_AUTO_TRIGGER_EN: when defined, a 10-bit counter SHALL count new_sample strobes in ARMED; at the 1024th strobe without a crossing, that sample SHALL be forced as the trigger (handled as in REQ-013), and the counter SHALL clear on leaving ARMED.
REQ-028 Without WAVE_CAPTURE_AUTO_TRIGGER_EN, the counter SHALL be absent and ARMED SHALL wait indefinitely for a crossing.

Structure
REQ-029 Shared package wave_pkg SHALL hold the state encodings, NUM_SAMPLES=256 and AUTO_TRIG_LIMIT=1024.
REQ-030 The crossing test and the offset conversion SHALL live in one combinational sub-module, wave_zero_cross; everything else SHALL be in wave_capture_ctrl.

Verification
REQ-031 Reset, then samples -5 then +3 -> exactly one cycle later: write_enable=1, write_address=0x100, write_sample=0x80; state=ACTIVE.
REQ-032 Continue with 255 more strobes -> final write at address 0x1FF, state=WAIT; 256 writes total, with none while in WAIT.
REQ-033 In WAIT, pulse frame_done -> read_index toggles 0->1 and state=ARMED; the next capture writes addresses 0x000..0x0FF.
REQ-034 frame_done pulsed during ACTIVE -> read_index unchanged; pulse coinciding with new_sample in WAIT -> no write, toggle occurs.
REQ-035 Reset pulsed after 100 writes -> all outputs 0, state=ARMED, next crossing restarts at index 0.
REQ-036 With WAVE_CAPTURE_AUTO_TRIGGER_EN and a constant +100 input -> trigger on the 1024th strobe and write_sample=0x80; without the macro -> no write after 2000 strobes.

Source files
------------

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared state encodings and sizing constants for the wave capture block
package wave_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_ILLEGAL = 2'd3
    } wave_state_t;

    localparam int NUM_SAMPLES     = 256;
    localparam int AUTO_TRIG_LIMIT = 1024;

endpackage

// File: rtl/wave_zero_cross.sv
// rtl/wave_zero_cross.sv - rising zero-crossing detect and signed-to-offset-binary conversion
module wave_zero_cross #(
    parameter int SAMPLE_W = 16
) (
    input  logic signed [SAMPLE_W-1:0] i_prev,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    output logic                       o_cross,
    output logic        [7:0]          o_offset
);

    localparam logic signed [SAMPLE_W-1:0] ZERO = '0;

    assign o_cross  = (i_prev < ZERO) && (i_sample >= ZERO);
    // Top byte with sign flipped is the +128 offset form expected by the display RAM
    assign o_offset = {~i_sample[SAMPLE_W-1], i_sample[SAMPLE_W-2:SAMPLE_W-8]};

endmodule

// File: rtl/wave_capture_ctrl.sv
// rtl/wave_capture_ctrl.sv - triggered 256-sample capture into a double-buffered wave RAM
// Optional macro WAVE_CAPTURE_AUTO_TRIGGER_EN forces a trigger after 1024 strobes without a crossing.
module wave_capture_ctrl #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                frame_done,
    output logic                write_enable,
    output logic [8:0]          write_address,
    output logic [7:0]          write_sample,
    output logic                read_index,
    output logic [1:0]          state
);

    import wave_pkg::*;

    localparam logic [7:0] LAST_INDEX = 8'(NUM_SAMPLES - 1);

    wave_state_t                 r_state;
    wave_state_t                 w_next_state;
    logic signed [SAMPLE_W-1:0]  r_prev;
    logic        [7:0]           r_index;
    logic        [7:0]           w_next_index;
    logic        [7:0]           w_wr_index;
    logic                        r_read_index;
    logic                        r_write_enable;
    logic        [8:0]           r_write_address;
    logic        [7:0]           r_write_sample;
    logic                        w_do_write;
    logic                        w_toggle;
    logic                        w_cross;
    logic        [7:0]           w_offset;
    logic                        w_auto_fire;

    wave_zero_cross #(.SAMPLE_W(SAMPLE_W)) u_zero_cross (
        .i_prev   (r_prev),
        .i_sample (sample_in),
        .o_cross  (w_cross),
        .o_offset (w_offset)
    );

`ifdef WAVE_CAPTURE_AUTO_TRIGGER_EN
    localparam logic [9:0] AUTO_LAST = 10'(AUTO_TRIG_LIMIT - 1);
    logic [9:0] r_auto_cnt;

    assign w_auto_fire = (r_auto_cnt == AUTO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_auto_cnt <= '0;
        end else if (r_state != ST_ARMED || w_next_state != ST_ARMED) begin
            r_auto_cnt <= '0;
        end else if (new_sample) begin
            r_auto_cnt <= r_auto_cnt + 10'd1;
        end
    end
`else
    assign w_auto_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_wr_index   = r_index;
        w_do_write   = 1'b0;
        w_toggle     = 1'b0;
        case (r_state)
            ST_ARMED: begin
                w_next_index = '0;
                if (new_sample && (w_cross || w_auto_fire)) begin
                    w_do_write   = 1'b1;
                    w_wr_index   = '0;
                    w_next_index = 8'd1;
                    w_next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample) begin
                    w_do_write = 1'b1;
                    if (r_index == LAST_INDEX) begin
                        w_next_index = '0;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_next_index = r_index + 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                // A coinciding new_sample is dropped here; only prev_sample sees it
                if (frame_done) begin
                    w_toggle     = 1'b1;
                    w_next_index = '0;
                    w_next_state = ST_ARMED;
                end
            end
            default: begin
                w_next_index = '0;
                w_next_state = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev          <= '0;
            r_index         <= '0;
            r_read_index    <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_sample  <= '0;
        end else begin
            if (new_sample) begin
                r_prev <= sample_in;
            end
            r_index        <= w_next_index;
            r_read_index   <= r_read_index ^ w_toggle;
            r_write_enable <= w_do_write;
            if (w_do_write) begin
                r_write_address <= {~r_read_index, w_wr_index};
                r_write_sample  <= w_offset;
            end
        end
    end

    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign write_sample  = r_write_sample;
    assign read_index    = r_read_index;
    assign state         = r_state;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb/tb_wave_capture_ctrl.sv - directed table-driven bench for wave_capture_ctrl
module tb_wave_capture_ctrl;

    localparam logic [1:0] S_ARMED  = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic        clk;
    logic        reset;
    logic        new_sample;
    logic [15:0] sample_in;
    logic        frame_done;
    logic        write_enable;
    logic [8:0]  write_address;
    logic [7:0]  write_sample;
    logic        read_index;
    logic [1:0]  state;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [15:0] s;
        logic        we;
        logic [8:0]  addr;
        logic [7:0]  ws;
        logic [1:0]  st;
    } vec_t;

    vec_t vt [8];

    wave_capture_ctrl #(.SAMPLE_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .new_sample    (new_sample),
        .sample_in     (sample_in),
        .frame_done    (frame_done),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_sample  (write_sample),
        .read_index    (read_index),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] s, input logic fd);
        @(negedge clk);
        new_sample = 1'b1;
        sample_in  = s;
        frame_done = fd;
        @(negedge clk);
        new_sample = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic pulse_fd();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] s;
        int          first_w;
        int          n_w;
        logic [7:0]  first_ws;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        new_sample = 1'b0;
        sample_in = '0;
        frame_done = 1'b0;

        vt[0] = '{16'sd3,      1'b0, 9'h000, 8'h00, S_ARMED};
        vt[1] = '{-16'sd5,     1'b0, 9'h000, 8'h00, S_ARMED};
        vt[2] = '{16'sd3,      1'b1, 9'h100, 8'h80, S_ACTIVE};
        vt[3] = '{16'h8000,    1'b1, 9'h101, 8'h00, S_ACTIVE};
        vt[4] = '{16'h7FFF,    1'b1, 9'h102, 8'hFF, S_ACTIVE};
        vt[5] = '{16'h1234,    1'b1, 9'h103, 8'h92, S_ACTIVE};
        vt[6] = '{16'hFF00,    1'b1, 9'h104, 8'h7F, S_ACTIVE};
        vt[7] = '{16'h0100,    1'b1, 9'h105, 8'h81, S_ACTIVE};

        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_ARMED));
        chk("rst_we", 32'(write_enable), 0);
        chk("rst_addr", 32'(write_address), 0);
        chk("rst_ws", 32'(write_sample), 0);
        chk("rst_ri", 32'(read_index), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            strobe(vt[i].s, 1'b0);
            chk($sformatf("vec%0d_we", i), 32'(write_enable), 32'(vt[i].we));
            chk($sformatf("vec%0d_st", i), 32'(state), 32'(vt[i].st));
            if (vt[i].we) begin
                chk($sformatf("vec%0d_addr", i), 32'(write_address), 32'(vt[i].addr));
                chk($sformatf("vec%0d_ws", i), 32'(write_sample), 32'(vt[i].ws));
            end
        end

        // single-cycle write strobe and frame_done ignored mid-capture
        pulse_fd();
        chk("act_fd_we", 32'(write_enable), 0);
        chk("act_fd_ri", 32'(read_index), 0);
        chk("act_fd_st", 32'(state), 32'(S_ACTIVE));

        for (int i = 6; i < 256; i++) begin
            s = 16'(i * 211 - 20000);
            strobe(s, 1'b0);
            chk($sformatf("cap1_we%0d", i), 32'(write_enable), 1);
            chk($sformatf("cap1_addr%0d", i), 32'(write_address), 32'(9'h100 + 9'(i)));
            chk($sformatf("cap1_ws%0d", i), 32'(write_sample), 32'(s[15:8] ^ 8'h80));
            chk($sformatf("cap1_st%0d", i), 32'(state), (i == 255) ? 32'(S_WAIT) : 32'(S_ACTIVE));
        end

        strobe(-16'sd3, 1'b0);
        chk("wait_no_write", 32'(write_enable), 0);
        chk("wait_st", 32'(state), 32'(S_WAIT));

        // coinciding strobe: no write, toggle, but -7 becomes prev_sample
        strobe(-16'sd7, 1'b1);
        chk("coin_we", 32'(write_enable), 0);
        chk("coin_ri", 32'(read_index), 1);
        chk("coin_st", 32'(state), 32'(S_ARMED));

        strobe(16'sd5, 1'b0);
        chk("cap2_trig_we", 32'(write_enable), 1);
        chk("cap2_trig_addr", 32'(write_address), 32'h000);
        chk("cap2_trig_ws", 32'(write_sample), 32'h80);
        chk("cap2_trig_st", 32'(state), 32'(S_ACTIVE));
        for (int i = 1; i < 100; i++) begin
            strobe(16'(i), 1'b0);
            chk($sformatf("cap2_addr%0d", i), 32'(write_address), 32'(i));
        end

        // asynchronous reset mid-capture
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'(S_ARMED));
        chk("arst_ri", 32'(read_index), 0);
        chk("arst_we", 32'(write_enable), 0);
        chk("arst_addr", 32'(write_address), 0);
        chk("arst_ws", 32'(write_sample), 0);
        @(negedge clk);
        reset = 1'b1;

        pulse_fd();
        chk("armed_fd_ri", 32'(read_index), 0);
        chk("armed_fd_st", 32'(state), 32'(S_ARMED));

        first_w = 0;
        n_w = 0;
        first_ws = 8'h00;
        for (int i = 1; i <= 2000; i++) begin
            strobe(16'sd100, 1'b0);
            if (write_enable) begin
                n_w++;
                if (first_w == 0) begin
                    first_w = i;
                    first_ws = write_sample;
                end
            end
        end
`ifdef WAVE_CAPTURE_AUTO_TRIGGER_EN
        chk("auto_first_strobe", 32'(first_w), 1024);
        chk("auto_first_ws", 32'(first_ws), 32'h80);
        chk("auto_writes", 32'(n_w), 256);
`else
        chk("noauto_writes", 32'(n_w), 0);
        chk("noauto_first", 32'(first_w), 0);
        chk("noauto_st", 32'(state), 32'(S_ARMED));
`endif

        do_reset();
        strobe(-16'sd1, 1'b0);
        chk("post_rst_neg_we", 32'(write_enable), 0);
        strobe(16'sd1, 1'b0);
        chk("post_rst_we", 32'(write_enable), 1);
        chk("post_rst_addr", 32'(write_address), 32'h100);
        chk("post_rst_st", 32'(state), 32'(S_ACTIVE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
